screen_mux: RTL and testbench
=============================

Name: screen_mux

Overview:
- Consumer end of the RGB interface: takes the start, game and gameover pixel streams (rgb_if.in) and drives the single RGB stream to the VGA output stage.
- Owns the top-level game-state FSM (START/GAME/GAMEOVER) and switches screens only at frame boundaries, so there is no tearing.
- Re-aligns the VGA sync/blank signals with its one-cycle output register.

Parameters:
- BG_COLOR, 12'h000, pixel emitted when the selected stream's valid is low.
- GAMEOVER_HOLD_FRAMES, 60, minimum frames in GAMEOVER before a restart press is accepted.
- FLASH_FRAMES, 8, flash length in frames (used only with SCREEN_FLASH_EN).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- rgb_in  rgb_if.in  -  rgb_start/rgb_game/rgb_gameover with valid_start/valid_game/valid_gameover
- vblnk_in  in  1  vertical blank
- hblnk_in  in  1  horizontal blank
- vsync_in  in  1  vertical sync
- hsync_in  in  1  horizontal sync
- btn_press  in  1  one-cycle pulse, debounced user button
- collision  in  1  one-cycle pulse from collision detector
- rgb_out  out  12  registered pixel
- vsync_out  out  1  vsync_in delayed 1 cycle
- hsync_out  out  1  hsync_in delayed 1 cycle
- game_state  out  2  current state_t
- game_rst  out  1  one-cycle pulse when GAME is entered

Behaviour:
- Reset (async, rst_n=0):
  - state=ST_START; rgb_out=12'h000; vsync_out=hsync_out=0; game_rst=0.
  - Pending flags, hold counter and flash counter all cleared.
- Frame boundary: single-cycle strobe on the rising edge of vblnk_in (vblnk_in=1 and previous value 0).
- Event latching:
  - btn_press and collision set sticky pending flags.
  - Flags clear when consumed at a frame boundary.
  - Flags are ignored in states where they are meaningless: collision outside GAME, btn outside START/GAMEOVER.
- FSM transitions, evaluated only on the frame-boundary strobe:
  - ST_START -> ST_GAME if btn pending; game_rst=1 in that same cycle.
  - ST_GAME -> ST_GAMEOVER if collision pending; hold counter loads GAMEOVER_HOLD_FRAMES.
  - ST_GAMEOVER:
    - Hold counter decrements once per frame boundary, saturating at 0.
    - Any btn arriving while the counter is nonzero is discarded.
    - -> ST_START when counter==0 and btn pending.
- Simultaneous events:
  - If btn_press or collision coincides with the boundary strobe, it is latched and acted on at the next boundary.
  - Exactly one transition per frame.
- Pixel path (1-cycle latency):
  - If hblnk_in|vblnk_in: rgb_out<=0.
  - Otherwise the stream for the current state; if its valid is 0, rgb_out<=BG_COLOR.
  - Stream by state: ST_START -> rgb_start, ST_GAME -> rgb_game, ST_GAMEOVER -> rgb_gameover.
  - The state used is the registered state, so the switch takes effect on the first pixel after the boundary.
- Sync: vsync_out/hsync_out are registered copies of vsync_in/hsync_in, aligned with rgb_out.
- Reset mid-frame: output is black and the FSM is in START immediately; the first boundary after reset is not special.

Optional Feature:
- Macro: SCREEN_FLASH_EN.
- When defined:
  - On entry to ST_GAMEOVER, the flash counter loads FLASH_FRAMES and decrements per frame boundary.
  - While nonzero and the frame's frame index (boundary count) is even, visible pixels output ~selected_pixel (bitwise invert, BG_COLOR included).
  - Blanking stays 0.
- When undefined: no flash counter or invert logic is synthesized; the pixel path is exactly as above.

Decomposition:
- Package game_pkg holds:
  - typedef enum logic [1:0] state_t {ST_START=2'd0, ST_GAME=2'd1, ST_GAMEOVER=2'd2}.
  - RGB_W=12.
  - Shared frame-count width FRAME_CNT_W=8.
- One natural sub-module, screen_fsm: boundary detect, pending flags, hold counter and state register; outputs state and game_rst.
- screen_mux keeps the pixel/sync pipeline and the flash logic.

Test Plan:
- Reset, then one full frame of rgb_start=12'hF00, valid_start=1 -> visible pixels 12'hF00 with 1-cycle latency; blanking 0; game_state=0.
- btn_press mid-frame -> state unchanged until the next vblnk rise, then game_state=1, game_rst high for exactly 1 cycle; next visible pixel equals rgb_game.
- In GAME, valid_game=0 with rgb_game=12'h0F0 -> rgb_out=BG_COLOR (12'h000); with valid_game=1 -> 12'h0F0.
- collision in GAME, then btn every frame -> GAMEOVER persists exactly GAMEOVER_HOLD_FRAMES (60) boundaries; the btn after expiry returns the state to 0.
- btn_press and collision asserted on the boundary-strobe cycle -> no transition at that boundary; acted on at the following boundary.
- rst_n asserted mid-line in GAMEOVER -> rgb_out=0 and game_state=0 without waiting for a clock edge; sync outputs 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and widths for the screen selection logic.
package game_pkg;
    localparam int RGB_W       = 12;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_START    = 2'd0,
        ST_GAME     = 2'd1,
        ST_GAMEOVER = 2'd2
    } state_t;
endpackage

// File: rtl/rgb_if.sv
// Bundle of the three screen pixel streams with their valid qualifiers.
interface rgb_if;
    import game_pkg::*;

    logic [RGB_W-1:0] rgb_start;
    logic [RGB_W-1:0] rgb_game;
    logic [RGB_W-1:0] rgb_gameover;
    logic             valid_start;
    logic             valid_game;
    logic             valid_gameover;

    modport in  (input  rgb_start, rgb_game, rgb_gameover,
                 input  valid_start, valid_game, valid_gameover);
    modport out (output rgb_start, rgb_game, rgb_gameover,
                 output valid_start, valid_game, valid_gameover);
endinterface

// File: rtl/screen_fsm.sv
// Game-state FSM: frame-boundary detect, sticky event flags, gameover hold counter.
module screen_fsm
    import game_pkg::*;
#(
    parameter int GAMEOVER_HOLD_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vblnk_in,
    input  logic       btn_press,
    input  logic       collision,
    output logic [1:0] state_o,
    output logic       game_rst_o
);

    state_t                 state_q, state_d;
    logic                   vblnk_q;
    logic                   btn_pend_q, btn_pend_d;
    logic                   col_pend_q, col_pend_d;
    logic                   game_rst_q, game_rst_d;
    logic [FRAME_CNT_W-1:0] hold_q, hold_d;
    logic                   boundary;
    logic                   btn_accept;
    logic                   col_accept;

    assign boundary = vblnk_in & ~vblnk_q;

    always_comb begin
        btn_accept = btn_press & ((state_q == ST_START) |
                                  ((state_q == ST_GAMEOVER) && (hold_q == '0)));
        col_accept = collision & (state_q == ST_GAME);
        state_d    = state_q;
        hold_d     = hold_q;
        game_rst_d = 1'b0;
        btn_pend_d = btn_pend_q | btn_accept;
        col_pend_d = col_pend_q | col_accept;

        if (boundary) begin
            // Decisions use only flags latched before this strobe; events on the
            // strobe cycle itself become the pending set for the next frame.
            btn_pend_d = btn_accept;
            col_pend_d = col_accept;
            case (state_q)
                ST_START: begin
                    if (btn_pend_q) begin
                        state_d    = ST_GAME;
                        game_rst_d = 1'b1;
                    end
                end
                ST_GAME: begin
                    if (col_pend_q) begin
                        state_d = ST_GAMEOVER;
                        hold_d  = FRAME_CNT_W'(GAMEOVER_HOLD_FRAMES);
                    end
                end
                ST_GAMEOVER: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - FRAME_CNT_W'(1);
                    end else if (btn_pend_q) begin
                        state_d = ST_START;
                    end
                end
                default: state_d = ST_START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_START;
            vblnk_q    <= 1'b0;
            btn_pend_q <= 1'b0;
            col_pend_q <= 1'b0;
            game_rst_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            vblnk_q    <= vblnk_in;
            btn_pend_q <= btn_pend_d;
            col_pend_q <= col_pend_d;
            game_rst_q <= game_rst_d;
            hold_q     <= hold_d;
        end
    end

    assign state_o    = state_q;
    assign game_rst_o = game_rst_q;

endmodule

// File: rtl/screen_mux.sv
// Selects the RGB stream for the current game screen and re-aligns sync.
// Optional gameover flash is enabled by defining SCREEN_FLASH_EN.
module screen_mux
    import game_pkg::*;
#(
    parameter logic [RGB_W-1:0] BG_COLOR             = 12'h000,
    parameter int               GAMEOVER_HOLD_FRAMES = 60
`ifdef SCREEN_FLASH_EN
    ,
    parameter int               FLASH_FRAMES         = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    rgb_if.in                rgb_in,
    input  logic             vblnk_in,
    input  logic             hblnk_in,
    input  logic             vsync_in,
    input  logic             hsync_in,
    input  logic             btn_press,
    input  logic             collision,
    output logic [RGB_W-1:0] rgb_out,
    output logic             vsync_out,
    output logic             hsync_out,
    output logic [1:0]       game_state,
    output logic             game_rst
);

    logic [1:0]       fsm_state;
    state_t           cur_state;
    logic [RGB_W-1:0] sel_pix;
    logic [RGB_W-1:0] pix;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             vsync_q, hsync_q;

    screen_fsm #(
        .GAMEOVER_HOLD_FRAMES(GAMEOVER_HOLD_FRAMES)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .vblnk_in   (vblnk_in),
        .btn_press  (btn_press),
        .collision  (collision),
        .state_o    (fsm_state),
        .game_rst_o (game_rst)
    );

    assign cur_state = state_t'(fsm_state);

    always_comb begin
        sel_pix = BG_COLOR;
        case (cur_state)
            ST_START:    if (rgb_in.valid_start)    sel_pix = rgb_in.rgb_start;
            ST_GAME:     if (rgb_in.valid_game)     sel_pix = rgb_in.rgb_game;
            ST_GAMEOVER: if (rgb_in.valid_gameover) sel_pix = rgb_in.rgb_gameover;
            default:     sel_pix = BG_COLOR;
        endcase
    end

`ifdef SCREEN_FLASH_EN
    logic                   flash_vblnk_q;
    logic                   frame_tick;
    state_t                 prev_state_q;
    logic [FRAME_CNT_W-1:0] flash_q;
    logic [FRAME_CNT_W-1:0] frame_idx_q;

    assign frame_tick = vblnk_in & ~flash_vblnk_q;

    // Entry is seen one cycle after the boundary, still inside vertical blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_vblnk_q <= 1'b0;
            prev_state_q  <= ST_START;
            flash_q       <= '0;
            frame_idx_q   <= '0;
        end else begin
            flash_vblnk_q <= vblnk_in;
            prev_state_q  <= cur_state;
            if (frame_tick) begin
                frame_idx_q <= frame_idx_q + FRAME_CNT_W'(1);
            end
            if ((cur_state == ST_GAMEOVER) && (prev_state_q != ST_GAMEOVER)) begin
                flash_q <= FRAME_CNT_W'(FLASH_FRAMES);
            end else if (frame_tick && (flash_q != '0)) begin
                flash_q <= flash_q - FRAME_CNT_W'(1);
            end
        end
    end

    assign pix = ((flash_q != '0) && !frame_idx_q[0]) ? ~sel_pix : sel_pix;
`else
    assign pix = sel_pix;
`endif

    assign rgb_d = (hblnk_in | vblnk_in) ? '0 : pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            vsync_q <= vsync_in;
            hsync_q <= hsync_in;
        end
    end

    assign rgb_out    = rgb_q;
    assign vsync_out  = vsync_q;
    assign hsync_out  = hsync_q;
    assign game_state = fsm_state;

endmodule

// File: tb/tb_screen_mux.sv
// Self-checking bench for screen_mux on a miniature 16x6 video raster.
module tb_screen_mux;
    import game_pkg::*;

    localparam int          H_TOT = 16;
    localparam int          H_VIS = 10;
    localparam int          V_TOT = 6;
    localparam int          V_VIS = 4;
    localparam int          FRAME = H_TOT * V_TOT;
    localparam int          HOLD  = 60;
    localparam logic [11:0] BG    = 12'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        vblnk_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, hsync_in = 1'b0;
    logic        btn_press = 1'b0, collision = 1'b0;
    logic [11:0] rgb_out;
    logic        vsync_out, hsync_out, game_rst;
    logic [1:0]  game_state;

    rgb_if rgb_bus();

    screen_mux dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rgb_in     (rgb_bus),
        .vblnk_in   (vblnk_in),
        .hblnk_in   (hblnk_in),
        .vsync_in   (vsync_in),
        .hsync_in   (hsync_in),
        .btn_press  (btn_press),
        .collision  (collision),
        .rgb_out    (rgb_out),
        .vsync_out  (vsync_out),
        .hsync_out  (hsync_out),
        .game_state (game_state),
        .game_rst   (game_rst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;
    int rst_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: screen id, events collected since the last boundary, hold frames left.
    int          m_state;
    bit          m_btn, m_col, m_vbp;
    int          m_hold;
    logic [11:0] e_rgb;
    bit          e_vs, e_hs, e_rst;

    task automatic model_reset();
        m_state = 0; m_btn = 0; m_col = 0; m_vbp = 0; m_hold = 0;
    endtask

    task automatic model_step();
        bit bnd, btn_ok, col_ok;
        bnd    = vblnk_in && !m_vbp;
        btn_ok = btn_press && (m_state == 0 || (m_state == 2 && m_hold == 0));
        col_ok = collision && (m_state == 1);
        if (hblnk_in || vblnk_in) e_rgb = 12'h000;
        else if (m_state == 0) e_rgb = rgb_bus.valid_start    ? rgb_bus.rgb_start    : BG;
        else if (m_state == 1) e_rgb = rgb_bus.valid_game     ? rgb_bus.rgb_game     : BG;
        else                   e_rgb = rgb_bus.valid_gameover ? rgb_bus.rgb_gameover : BG;
        e_vs = vsync_in; e_hs = hsync_in; e_rst = 0;
        if (bnd) begin
            if (m_state == 0 && m_btn) begin
                m_state = 1; e_rst = 1;
            end else if (m_state == 1 && m_col) begin
                m_state = 2; m_hold = HOLD;
            end else if (m_state == 2) begin
                if (m_hold > 0) m_hold--;
                else if (m_btn) m_state = 0;
            end
            m_btn = btn_ok; m_col = col_ok;
        end else begin
            m_btn = m_btn | btn_ok; m_col = m_col | col_ok;
        end
        m_vbp = vblnk_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("rgb_out",    rgb_out,    e_rgb);
        check("vsync_out",  vsync_out,  e_vs);
        check("hsync_out",  hsync_out,  e_hs);
        check("game_state", game_state, m_state);
        check("game_rst",   game_rst,   e_rst);
        if (game_rst) rst_pulses++;
    endtask

    task automatic randomize_pixels();
        rgb_bus.rgb_start      = 12'($urandom);
        rgb_bus.rgb_game       = 12'($urandom);
        rgb_bus.rgb_gameover   = 12'($urandom);
        rgb_bus.valid_start    = 1'($urandom_range(0, 1));
        rgb_bus.valid_game     = 1'($urandom_range(0, 1));
        rgb_bus.valid_gameover = 1'($urandom_range(0, 1));
    endtask

    // One raster frame; vblnk rises at cycle H_TOT*V_VIS (64).
    task automatic run_frame(input int btn_at, input int col_at, input int stop_at, input bit rand_pix);
        for (int c = 0; c < FRAME; c++) begin
            int ln, px;
            if (c == stop_at) break;
            ln = c / H_TOT;
            px = c % H_TOT;
            hblnk_in  = (px >= H_VIS);
            vblnk_in  = (ln >= V_VIS);
            hsync_in  = (px >= 12 && px < 14);
            vsync_in  = (ln == 5);
            btn_press = (c == btn_at);
            collision = (c == col_at);
            if (rand_pix) randomize_pixels();
            tick();
        end
        btn_press = 1'b0;
        collision = 1'b0;
        frame_no++;
        $display("frame %0d: btn@%0d col@%0d -> game_state %0d", frame_no, btn_at, col_at, game_state);
    endtask

    typedef struct {
        bit          hb;
        bit          vb;
        bit          valid;
        logic [11:0] pix;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{0, 0, 1, 12'hF00, 12'hF00};
        vecs[1] = '{0, 0, 0, 12'hF00, BG};
        vecs[2] = '{1, 0, 1, 12'hABC, 12'h000};
        vecs[3] = '{0, 1, 1, 12'hABC, 12'h000};
        vecs[4] = '{1, 1, 1, 12'hFFF, 12'h000};
        vecs[5] = '{0, 0, 1, 12'hFFF, 12'hFFF};
        vecs[6] = '{0, 0, 1, 12'h001, 12'h001};
        vecs[7] = '{0, 0, 0, 12'h5A5, BG};

        randomize_pixels();
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rgb",   rgb_out,    12'h000);
        check("rst_state", game_state, 2'd0);
        check("rst_grst",  game_rst,   1'b0);
        check("rst_vsync", vsync_out,  1'b0);
        check("rst_hsync", hsync_out,  1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        rst_n = 1'b1;

        // Pixel mux in START, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            hblnk_in = vecs[i].hb;
            vblnk_in = vecs[i].vb;
            rgb_bus.rgb_start   = vecs[i].pix;
            rgb_bus.valid_start = vecs[i].valid;
            tick();
            check("table_rgb", rgb_out, vecs[i].exp);
            $display("vector %0d: hb=%0d vb=%0d valid=%0d pix=%h -> rgb_out=%h", i,
                     vecs[i].hb, vecs[i].vb, vecs[i].valid, vecs[i].pix, rgb_out);
        end

        rgb_bus.rgb_start = 12'hF00; rgb_bus.valid_start = 1'b1;
        rgb_bus.rgb_game  = 12'h0F0; rgb_bus.valid_game  = 1'b1;
        run_frame(-1, -1, FRAME, 0);
        check("start_idle_state", game_state, 2'd0);

        rst_pulses = 0;
        run_frame(30, -1, FRAME, 0);
        check("enter_game_state", game_state, 2'd1);
        check("game_rst_pulses", rst_pulses, 1);

        rgb_bus.valid_game = 1'b0;
        run_frame(-1, -1, FRAME, 0);
        rgb_bus.valid_game = 1'b1;
        run_frame(-1, -1, FRAME, 0);

        run_frame(-1, 64, FRAME, 1);
        check("coincident_col_state", game_state, 2'd1);
        run_frame(-1, -1, FRAME, 1);
        check("gameover_state", game_state, 2'd2);

        n = 0;
        while (game_state == 2'd2 && n < 80) begin
            run_frame(10, -1, FRAME, 1);
            n++;
        end
        check("gameover_frames", n, HOLD + 1);

        run_frame(64, -1, FRAME, 1);
        check("coincident_btn_state", game_state, 2'd0);
        run_frame(-1, -1, FRAME, 1);
        check("late_btn_state", game_state, 2'd1);
        run_frame(-1, 20, FRAME, 1);
        check("collide_state", game_state, 2'd2);

        // Asynchronous reset in the middle of a visible gameover line
        rgb_bus.rgb_gameover = 12'hABC; rgb_bus.valid_gameover = 1'b1;
        run_frame(-1, -1, 19, 0);
        check("pre_reset_rgb", rgb_out, 12'hABC);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rgb",   rgb_out,    12'h000);
        check("midrst_state", game_state, 2'd0);
        check("midrst_vsync", vsync_out,  1'b0);
        check("midrst_hsync", hsync_out,  1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int f = 0; f < 30; f++) begin
            int b, cl;
            b  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, FRAME - 1));
            cl = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, FRAME - 1));
            run_frame(b, cl, FRAME, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
